dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS core. It sits on the far side of the core's CEN/WEN/OEN/A/Data2Mem/ReadDataMem interface.
- It holds a 2^ADDR_W x 32 word array behind a small posted-write buffer.
- Reads are combinational, as the single-cycle core requires. Buffered writes are forwarded, youngest match first.
- Buffered writes drain to the array in order on idle cycles, which models a single-write-port RAM.

Parameters:
- ADDR_W, 7, word-address width; array depth is 2^ADDR_W (128 words).
- WB_DEPTH, 4, posted-write buffer entries; must be a power of two, at least 2.
- CNT_W, 3, width of wb_count; equals log2(WB_DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset. Named as the active-high counterpart of the core's rst_n.
- CEN  in  1  chip enable, active low.
- WEN  in  1  write enable, active low.
- OEN  in  1  output (read) enable, active low.
- A  in  ADDR_W  word address (the core drives ALU_result[8:2]).
- D  in  32  write data (the core's Data2Mem).
- Q  out  32  read data (the core's ReadDataMem).
- wb_count  out  CNT_W  current buffer occupancy.
- wb_full  out  1  wb_count == WB_DEPTH.
- fwd_hit  out  1  the current read is served from the buffer.

Behaviour:
- Access decode each cycle:
  - write = ~CEN & ~WEN.
  - read = ~CEN & WEN & ~OEN.
  - idle = otherwise.
  - Write has priority when both WEN and OEN are low.
- Reset (async, rst=1):
  - All array words = 0.
  - Buffer pointers = 0 and all entry valid bits = 0.
  - wb_count = 0, wb_full = 0.
  - Q = 0 (array is zero), fwd_hit = 0.
  - Reset asserted mid-drain discards all pending entries.
- Buffer structure: a circular FIFO of {addr, data} with head (oldest) and tail pointers, plus an occupancy counter.
- Enqueue on a write: {A, D} is stored at the tail at the rising edge, tail += 1 (wrapping).
- Drain:
  - Drain fires at the rising edge when wb_count != 0 AND (idle OR (write AND wb_full)).
  - The head entry is written to array[addr], then head += 1 (wrapping).
  - A read never drains.
- Count update:
  - Enqueue only: +1.
  - Drain only: −1.
  - Both (full write): count unchanged, and the new entry takes the freed slot.
  - The buffer therefore never overflows and never loses a write.
- Read path (combinational, zero latency):
  - Q = data of the youngest valid buffer entry whose addr == A, else array[A]. fwd_hit = 1 when a buffer entry supplies Q.
  - Q follows the same rule on every non-read cycle as well, so it is deterministic. fwd_hit is 0 whenever read = 0.
  - On a write cycle, Q reflects the state before the edge; the new data becomes visible the next cycle.
- Youngest-match priority: the search runs from tail−1 back to head, so duplicate addresses resolve to the newest data.
  - Drain order matches program order, so the array ends up holding the last write.
- Simultaneous full-write and drain to the same address:
  - The array gets the old entry and the buffer gets the new one.
  - A following read returns the new data from the buffer.
- Address width: A indexes words directly with no byte lanes; every write is a full 32-bit word.
- wb_count and wb_full are registered; fwd_hit and Q are combinational.

Decomposition:
- Shared package (mips_mem_pkg):
  - ADDR_W default, data width 32.
  - Access-type encoding {IDLE, READ, WRITE}.
  - The buffer-entry struct {valid, addr, data}.
- Sub-module wb_fifo: the circular buffer with pointers, counter, enqueue/drain strobes and a parallel youngest-match lookup port.
- The top level holds the array, the access decode, the drain policy and the Q mux.

Test Plan:
- Reset: assert rst mid-sequence with 2 entries pending, then read A=5 → Q=0, wb_count=0, fwd_hit=0.
- Forward: write A=3 D=0xDEADBEEF, then read A=3 next cycle → Q=0xDEADBEEF, fwd_hit=1, wb_count=1. One idle cycle → wb_count=0. Read A=3 → same Q with fwd_hit=0.
- Duplicate address: write A=7 D=1, write A=7 D=2, read A=7 → Q=2. Two idle cycles, then read A=7 → Q=2 from the array.
- Full buffer: 4 back-to-back writes A=0..3 D=0x10..0x13 → wb_full=1. Write A=4 D=0x14 → wb_count stays 4 and array[0]=0x10. Reads of A=0..4 → 0x10..0x14.
- Reads block drain: 3 writes, then 10 reads of A=9 (Q=0) → wb_count stays 3. One idle cycle → wb_count=2.
- WEN=0 and OEN=0 together with A=1 D=0xA5 → treated as a write; Q shows the old value that cycle, and a read the next cycle returns 0xA5.

Source files
------------

// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Purpose  : Shared types for the MIPS data-memory responder.
// Revision : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam int MEM_ADDR_W = 7;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_t;

    // Entry address field is sized by MEM_ADDR_W; responders use that width.
    typedef struct packed {
        logic                  valid;
        logic [MEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Write wins when WEN and OEN are both low.
    function automatic access_t decode_access(input logic cen, input logic wen,
                                              input logic oen);
        access_t acc;
        acc = ACC_IDLE;
        if (!cen && !wen)
            acc = ACC_WRITE;
        else if (!cen && !oen)
            acc = ACC_READ;
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular posted-write buffer with youngest-match lookup port.
// Revision : 1.0
// ============================================================================
module wb_fifo
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enq,
    input  logic [MEM_ADDR_W-1:0] enq_addr,
    input  logic [DATA_W-1:0]     enq_data,
    input  logic                  drain,
    output logic [MEM_ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    input  logic [MEM_ADDR_W-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [DATA_W-1:0]     lookup_data
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        r_entry [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_idx;

    // On a full write head == tail, so the enqueue below overrides the drain clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_entry[i] <= '0;
        end else begin
            if (drain) begin
                r_entry[r_head].valid <= 1'b0;
                r_head                <= r_head + PTR_W'(1);
            end
            if (enq) begin
                r_entry[r_tail] <= '{valid: 1'b1, addr: enq_addr, data: enq_data};
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_addr = r_entry[r_head].addr;
    assign head_data = r_entry[r_head].data;
    assign count     = r_count;
    assign full      = (r_count == CNT_W'(DEPTH));

    // Scan oldest to youngest so the last match (the newest write) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        w_idx       = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (r_entry[w_idx].valid && (r_entry[w_idx].addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_entry[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Word-array data memory with posted-write buffer and forwarding.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int WB_DEPTH = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       D,
    output logic [31:0]       Q,
    output logic [CNT_W-1:0]  wb_count,
    output logic              wb_full,
    output logic              fwd_hit
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    access_t           w_acc;
    logic              w_write;
    logic              w_read;
    logic              w_idle;
    logic              w_drain;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd_data;

    assign w_acc   = decode_access(CEN, WEN, OEN);
    assign w_write = (w_acc == ACC_WRITE);
    assign w_read  = (w_acc == ACC_READ);
    assign w_idle  = (w_acc == ACC_IDLE);

    // A full buffer drains alongside the incoming write so nothing is lost.
    assign w_drain = (wb_count != '0) && (w_idle || (w_write && wb_full));

    wb_fifo #(
        .DEPTH (WB_DEPTH),
        .CNT_W (CNT_W)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .enq         (w_write),
        .enq_addr    (A),
        .enq_data    (D),
        .drain       (w_drain),
        .head_addr   (w_head_addr),
        .head_data   (w_head_data),
        .count       (wb_count),
        .full        (wb_full),
        .lookup_addr (A),
        .lookup_hit  (w_hit),
        .lookup_data (w_fwd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++)
                r_mem[i] <= '0;
        end else if (w_drain) begin
            r_mem[w_head_addr] <= w_head_data;
        end
    end

    assign Q       = w_hit ? w_fwd_data : r_mem[A];
    assign fwd_hit = w_read & w_hit;

endmodule
`default_nettype wire
